// File: rtl/plc_arb_pkg.sv
// rtl/plc_arb_pkg.sv - shared constants and helpers for the PLC data RAM write arbiter
package plc_arb_pkg;

  localparam int ARB_MODE_FIXED = 0;
  localparam int ARB_MODE_RR    = 1;
  localparam int PLC_DATA_W     = 8;
  localparam int PLC_ADDR_W     = 16;
  localparam int PLC_MAX_CORES  = 16;

  // Caller guarantees at most one bit set; zero maps to index 0.
  function automatic logic [3:0] onehot_to_idx(input logic [PLC_MAX_CORES-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < PLC_MAX_CORES; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/write_arb_pick.sv
// rtl/write_arb_pick.sv - combinational round-robin / fixed-priority grant picker
module write_arb_pick import plc_arb_pkg::*; #(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = $clog2(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IDX_W-1:0]     last,
  input  logic                 mode,
  output logic [NUM_CORES-1:0] grant_onehot,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 any
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_onehot = '0;
    found        = 1'b0;
    cand         = '0;
    if (mode) begin
      // Search starts one past the last winner and wraps around.
      for (int k = 1; k <= NUM_CORES; k++) begin
        cand = IDX_W'((int'(last) + k) % NUM_CORES);
        if (!found && req[cand]) begin
          grant_onehot[cand] = 1'b1;
          found              = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (!found && req[i]) begin
          grant_onehot[i] = 1'b1;
          found           = 1'b1;
        end
      end
    end
  end

  assign any       = |req;
  assign grant_idx = IDX_W'(onehot_to_idx(PLC_MAX_CORES'(grant_onehot)));

endmodule

// File: rtl/rr_write_arbiter.sv
// rtl/rr_write_arbiter.sv - N-core one-deep write slots arbitrated onto a single registered RAM write port
module rr_write_arbiter import plc_arb_pkg::*; #(
  parameter int NUM_CORES = 4,
  parameter int DATA_W    = PLC_DATA_W,
  parameter int ADDR_W    = PLC_ADDR_W,
  parameter int RR_MODE   = ARB_MODE_RR
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [NUM_CORES-1:0]          CORE_WE,
  input  logic [NUM_CORES*DATA_W-1:0]   CORE_WDATA,
  input  logic [NUM_CORES*ADDR_W-1:0]   CORE_WADDR,
  output logic [NUM_CORES-1:0]          CORE_READY,
  output logic [NUM_CORES-1:0]          CORE_ACK,
  output logic                          RAM_WE,
  output logic [DATA_W-1:0]             RAM_WDATA,
  output logic [ADDR_W-1:0]             RAM_WADDR,
  output logic                          BUSY
);

  localparam int   IDX_W    = $clog2(NUM_CORES);
  localparam logic MODE_BIT = (RR_MODE == ARB_MODE_RR);

  logic [NUM_CORES-1:0] pend;
  logic [DATA_W-1:0]    slot_data [NUM_CORES];
  logic [ADDR_W-1:0]    slot_addr [NUM_CORES];
  logic [IDX_W-1:0]     last;

  logic [NUM_CORES-1:0] grant_onehot;
  logic [IDX_W-1:0]     grant_idx;
  logic                 any;

  write_arb_pick #(
    .NUM_CORES (NUM_CORES),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req          (pend),
    .last         (last),
    .mode         (MODE_BIT),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any          (any)
  );

  assign CORE_READY = ~pend;
  assign BUSY       = |pend;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pend      <= '0;
      last      <= IDX_W'(NUM_CORES - 1);
      CORE_ACK  <= '0;
      RAM_WE    <= 1'b0;
      RAM_WDATA <= '0;
      RAM_WADDR <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        slot_data[i] <= '0;
        slot_addr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (CORE_WE[i] && !pend[i]) begin
          pend[i]      <= 1'b1;
          slot_data[i] <= CORE_WDATA[i*DATA_W +: DATA_W];
          slot_addr[i] <= CORE_WADDR[i*ADDR_W +: ADDR_W];
        end
      end
      // A granted slot was not ready this edge, so its clear never races a capture.
      if (any) begin
        RAM_WE          <= 1'b1;
        RAM_WDATA       <= slot_data[grant_idx];
        RAM_WADDR       <= slot_addr[grant_idx];
        CORE_ACK        <= grant_onehot;
        pend[grant_idx] <= 1'b0;
        if (MODE_BIT) last <= grant_idx;
      end else begin
        RAM_WE    <= 1'b0;
        RAM_WDATA <= '0;
        RAM_WADDR <= '0;
        CORE_ACK  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rr_write_arbiter.sv
// tb/tb_rr_write_arbiter.sv - randomized and directed checks of rr_write_arbiter in both arbitration modes
module tb_rr_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 16;

  logic            CLK;
  logic            RST_N;
  logic [N-1:0]    CORE_WE;
  logic [N*DW-1:0] CORE_WDATA;
  logic [N*AW-1:0] CORE_WADDR;

  logic [N-1:0]  rdy_r, ack_r, rdy_f, ack_f;
  logic          we_r, busy_r, we_f, busy_f;
  logic [DW-1:0] wd_r, wd_f;
  logic [AW-1:0] wa_r, wa_f;

  int vectors    = 0;
  int miscompares = 0;

  rr_write_arbiter #(.NUM_CORES(N), .DATA_W(DW), .ADDR_W(AW), .RR_MODE(1)) dut_rr (
    .CLK(CLK), .RST_N(RST_N), .CORE_WE(CORE_WE), .CORE_WDATA(CORE_WDATA), .CORE_WADDR(CORE_WADDR),
    .CORE_READY(rdy_r), .CORE_ACK(ack_r), .RAM_WE(we_r), .RAM_WDATA(wd_r), .RAM_WADDR(wa_r), .BUSY(busy_r)
  );

  rr_write_arbiter #(.NUM_CORES(N), .DATA_W(DW), .ADDR_W(AW), .RR_MODE(0)) dut_fx (
    .CLK(CLK), .RST_N(RST_N), .CORE_WE(CORE_WE), .CORE_WDATA(CORE_WDATA), .CORE_WADDR(CORE_WADDR),
    .CORE_READY(rdy_f), .CORE_ACK(ack_f), .RAM_WE(we_f), .RAM_WDATA(wd_f), .RAM_WADDR(wa_f), .BUSY(busy_f)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: index 0 = round-robin instance, 1 = fixed-priority instance.
  bit            armed = 1'b0;
  bit            m_pend [2][N];
  logic [DW-1:0] m_sd   [2][N];
  logic [AW-1:0] m_sa   [2][N];
  int            m_last [2];
  logic [N-1:0]  m_ack  [2];
  logic          m_we   [2];
  logic [DW-1:0] m_wd   [2];
  logic [AW-1:0] m_wa   [2];

  always @(posedge CLK) begin
    for (int m = 0; m < 2; m++) begin
      if (!RST_N) begin
        for (int c = 0; c < N; c++) begin
          m_pend[m][c] = 1'b0; m_sd[m][c] = '0; m_sa[m][c] = '0;
        end
        m_last[m] = N - 1;
        m_ack[m] = '0; m_we[m] = 1'b0; m_wd[m] = '0; m_wa[m] = '0;
      end else begin
        int  g;
        bit  was_pend [N];
        g = -1;
        for (int c = 0; c < N; c++) was_pend[c] = m_pend[m][c];
        if (m == 0) begin
          for (int k = 1; k <= N; k++)
            if (g < 0 && was_pend[(m_last[m] + k) % N]) g = (m_last[m] + k) % N;
        end else begin
          for (int c = N - 1; c >= 0; c--) if (was_pend[c]) g = c;
        end
        if (g >= 0) begin
          m_we[m] = 1'b1; m_ack[m] = N'(1) << g; m_wd[m] = m_sd[m][g]; m_wa[m] = m_sa[m][g];
          if (m == 0) m_last[m] = g;
        end else begin
          m_we[m] = 1'b0; m_ack[m] = '0; m_wd[m] = '0; m_wa[m] = '0;
        end
        for (int c = 0; c < N; c++) begin
          if (CORE_WE[c] && !was_pend[c]) begin
            m_pend[m][c] = 1'b1;
            m_sd[m][c] = CORE_WDATA[c*DW +: DW];
            m_sa[m][c] = CORE_WADDR[c*AW +: AW];
          end
        end
        if (g >= 0) m_pend[m][g] = 1'b0;
      end
    end
    armed = 1'b1;
  end

  function automatic logic [N-1:0] exp_ready(input int m);
    logic [N-1:0] r;
    for (int c = 0; c < N; c++) r[c] = ~m_pend[m][c];
    return r;
  endfunction

  always @(negedge CLK) begin
    if (armed) begin
      chk("rr_ready", rdy_r, exp_ready(0));
      chk("rr_ack",   ack_r, m_ack[0]);
      chk("rr_we",    we_r,  m_we[0]);
      chk("rr_wdata", wd_r,  m_wd[0]);
      chk("rr_waddr", wa_r,  m_wa[0]);
      chk("rr_busy",  busy_r, ~&exp_ready(0));
      chk("fx_ready", rdy_f, exp_ready(1));
      chk("fx_ack",   ack_f, m_ack[1]);
      chk("fx_we",    we_f,  m_we[1]);
      chk("fx_wdata", wd_f,  m_wd[1]);
      chk("fx_waddr", wa_f,  m_wa[1]);
      chk("fx_busy",  busy_f, ~&exp_ready(1));
    end
  end

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST_N = 1'b0; CORE_WE = '0;
    step();
    RST_N = 1'b1;
  endtask

  initial begin
    RST_N = 1'b0; CORE_WE = '0; CORE_WDATA = '0; CORE_WADDR = '0;

    // Reset with random requests
    for (int i = 0; i < 2; i++) begin
      CORE_WE = N'($urandom); CORE_WDATA = $urandom; CORE_WADDR = {$urandom, $urandom};
      step();
    end
    chk("t1_ready", rdy_r, 4'b1111);
    chk("t1_busy",  busy_r, 1'b0);
    chk("t1_out",   {ack_r, we_r, wd_r, wa_r}, '0);

    // Single write from core 2
    RST_N = 1'b1; CORE_WE = '0;
    step();
    CORE_WE = 4'b0100; CORE_WADDR[2*AW +: AW] = 16'h1234; CORE_WDATA[2*DW +: DW] = 8'hA5;
    step();
    chk("t2_ready_low", rdy_r, 4'b1011);
    CORE_WE = '0;
    step();
    chk("t2_we",    we_r, 1'b1);
    chk("t2_waddr", wa_r, 16'h1234);
    chk("t2_wdata", wd_r, 8'hA5);
    chk("t2_ack",   ack_r, 4'b0100);
    step();
    chk("t2_we_off", we_r, 1'b0);
    chk("t2_ready",  rdy_r, 4'b1111);

    // Round-robin contention with core 0 re-requesting
    do_reset();
    CORE_WE = 4'b1111; CORE_WDATA = 32'h44332211;
    step();
    CORE_WE = 4'b0001; CORE_WDATA[7:0] = 8'h5A;
    step();
    chk("t3_ack0", ack_r, 4'b0001);
    step();
    chk("t3_ack1", ack_r, 4'b0010);
    CORE_WE = '0;
    step();
    chk("t3_ack2", ack_r, 4'b0100);
    step();
    chk("t3_ack3", ack_r, 4'b1000);
    step();
    chk("t3_ack0b", ack_r, 4'b0001);
    chk("t3_data0b", wd_r, 8'h5A);

    // Fixed priority, cores 1 and 3 continuously requesting
    do_reset();
    CORE_WE = 4'b1010;
    step();
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t4_fx_ack", ack_f, (i % 2 == 0) ? 4'b0010 : 4'b1000);
    end
    CORE_WE = '0;

    // Back-pressure on core 0 with changing data
    do_reset();
    CORE_WE = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      CORE_WDATA[7:0] = 8'(8'h10 + k);
      step();
      if (k == 1) begin
        chk("t5_ack", ack_r, 4'b0001);
        chk("t5_data", wd_r, 8'h10);
      end
      if (k == 2) chk("t5_idle", we_r, 1'b0);
    end
    CORE_WE = '0;
    step();
    chk("t5_data2", wd_r, 8'h12);
    step();
    chk("t5_nodup", {we_r, ack_r}, '0);

    // Reset with three slots pending
    do_reset();
    CORE_WE = 4'b0111;
    step();
    chk("t6_busy_pre", busy_r, 1'b1);
    RST_N = 1'b0; CORE_WE = '0;
    step();
    chk("t6_busy", busy_r, 1'b0);
    chk("t6_quiet", {we_r, ack_r}, '0);
    RST_N = 1'b1;
    step();
    chk("t6_quiet2", {we_r, ack_r}, '0);
    CORE_WE = 4'b1010;
    step();
    CORE_WE = '0;
    step();
    chk("t6_first", ack_r, 4'b0010);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      RST_N      = ($urandom_range(0, 199) != 0);
      CORE_WE    = N'($urandom);
      CORE_WDATA = $urandom;
      CORE_WADDR = {$urandom, $urandom};
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
